// File: rtl/axis_serializer_pkg.sv
// rtl/axis_serializer_pkg.sv - shared state enum and beat-count helper for axis_serializer
package axis_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A requested count of 0, or anything above the configured maximum, means a full packet.
  function automatic int eff_beats(input int req, input int max_beats);
    if (req == 0 || req > max_beats) return max_beats;
    return req;
  endfunction

endpackage

// File: rtl/axis_if.sv
// rtl/axis_if.sv - stream interface carrying TVALID/TREADY/TDATA/TLAST
interface axis_if #(
  parameter int DW = 32
);
  logic          TVALID;
  logic          TREADY;
  logic [DW-1:0] TDATA;
  logic          TLAST;

  modport m (output TVALID, output TDATA, output TLAST, input TREADY);
  modport s (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

// File: rtl/axis_serializer.sv
// rtl/axis_serializer.sv - wide word to stream beat serializer; TLAST under AXIS_SERIALIZER_TLAST_EN
module axis_serializer
  import axis_serializer_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int BEATS           = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [AXIS_DATA_WIDTH*BEATS-1:0]   in_data,
  input  logic [$clog2(BEATS+1)-1:0]         in_beats,
  axis_if.m                                  m_axis,
  output logic                               busy
);

  localparam int IW = $clog2(BEATS);

  state_t                                  r_state;
  logic [BEATS-1:0][AXIS_DATA_WIDTH-1:0]   r_word;
  logic [IW-1:0]                           r_idx;
  logic [IW-1:0]                           r_last;
  logic                                    r_rst_done;

  logic w_fire;
  logic w_final;
  logic w_load;

  assign w_fire  = (r_state == SEND) && m_axis.TREADY;
  assign w_final = (r_idx == r_last);
  // Accepting on the final-beat handshake keeps back-to-back packets free of bubbles.
  assign in_ready = r_rst_done && ((r_state == IDLE) || (w_fire && w_final));
  assign w_load   = in_valid && in_ready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_word  <= in_data;
            r_idx   <= '0;
            r_last  <= IW'(eff_beats(int'(in_beats), BEATS) - 1);
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_fire) begin
            if (w_final) begin
              if (w_load) begin
                r_word  <= in_data;
                r_idx   <= '0;
                r_last  <= IW'(eff_beats(int'(in_beats), BEATS) - 1);
                r_state <= SEND;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = (r_state == SEND);
  assign m_axis.TVALID = busy;
  assign m_axis.TDATA  = r_word[r_idx];

`ifdef AXIS_SERIALIZER_TLAST_EN
  assign m_axis.TLAST = busy && w_final;
`else
  assign m_axis.TLAST = 1'b0;
`endif

endmodule

// File: tb/tb_axis_serializer.sv
// tb/tb_axis_serializer.sv - self-checking bench for axis_serializer (optionally AXIS_SERIALIZER_TLAST_EN)
module tb_axis_serializer;

  localparam int W  = 32;
  localparam int B  = 4;
  localparam int CW = $clog2(B + 1);

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             busy;
  logic [W*B-1:0]   in_data = '0;
  logic [CW-1:0]    in_beats = '0;

  axis_if #(.DW(W)) m_axis_if ();

  axis_serializer #(.AXIS_DATA_WIDTH(W), .BEATS(B)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_beats (in_beats),
    .m_axis   (m_axis_if),
    .busy     (busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    logic [W*B-1:0] data;
    logic [CW-1:0]  beats;
    int             exp_n;
  } vec_t;

  beat_t q[$];
  int    vecs = 0;
  int    miss = 0;
  int    beats_seen = 0;
  bit    tr_rand = 1'b0;
  logic  tr_pat[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready pattern driver: queued pattern first, then either random or held high.
  initial forever begin
    @(posedge ACLK);
    #1;
    if (tr_rand) m_axis_if.TREADY = 1'($urandom_range(0, 1));
    else if (tr_pat.size() > 0) m_axis_if.TREADY = tr_pat.pop_front();
    else m_axis_if.TREADY = 1'b1;
  end

  // Reference model: every accepted word becomes a list of expected beats.
  logic         pv, pr, pl;
  logic [W-1:0] pd;
  always @(negedge ACLK) begin
    int    n;
    beat_t e;
    if (!ARESETn) begin
      q.delete();
      chk("rst_tvalid", m_axis_if.TVALID, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tdata", m_axis_if.TDATA, 0);
      chk("rst_tlast", m_axis_if.TLAST, 0);
      pv = 1'b0;
    end else begin
      chk("busy_vs_tvalid", busy, m_axis_if.TVALID);
      if (pv && !pr) begin
        chk("stall_tvalid", m_axis_if.TVALID, 1);
        chk("stall_tdata", m_axis_if.TDATA, pd);
        chk("stall_tlast", m_axis_if.TLAST, pl);
      end
      if (q.size() > 0) chk("tvalid_pending", m_axis_if.TVALID, 1);
      if (m_axis_if.TVALID && m_axis_if.TREADY) begin
        if (q.size() == 0) begin
          vecs++;
          miss++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t", m_axis_if.TDATA, $time);
        end else begin
          e = q.pop_front();
          chk("beat_tdata", m_axis_if.TDATA, e.d);
          chk("beat_tlast", m_axis_if.TLAST, e.l);
          beats_seen++;
        end
      end
      if (in_valid && in_ready) begin
        n = (in_beats == 0 || int'(in_beats) > B) ? B : int'(in_beats);
        for (int i = 0; i < n; i++) begin
          e.d = W'(in_data >> (i * W));
`ifdef AXIS_SERIALIZER_TLAST_EN
          e.l = (i == n - 1);
`else
          e.l = 1'b0;
`endif
          q.push_back(e);
        end
      end
      pv = m_axis_if.TVALID;
      pr = m_axis_if.TREADY;
      pd = m_axis_if.TDATA;
      pl = m_axis_if.TLAST;
    end
  end

  task automatic send_pkt(input logic [W*B-1:0] d, input logic [CW-1:0] n, input bit hold);
    int t = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_beats = n;
    while (!acc && t < 200) begin
      @(negedge ACLK);
      acc = in_ready;
      @(posedge ACLK);
      #1;
      t++;
    end
    if (!acc) begin
      vecs++;
      miss++;
      $display("FAIL accept_timeout: got no in_ready, expected accept within 200 cycles");
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() > 0 || m_axis_if.TVALID) && t < 500) begin
      @(posedge ACLK);
      #1;
      t++;
    end
    if (t >= 500) begin
      vecs++;
      miss++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
    end
  endtask

  initial begin
    vec_t tbl[7];
    int   t;
    tbl[0] = '{128'h44444444_33333333_22222222_11111111, 3'd0, 4};
    tbl[1] = '{128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 3'd3, 3};
    tbl[2] = '{128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 3'd2, 2};
    tbl[3] = '{128'hA5A5A5A5_5A5A5A5A_01010101_FEFEFEFE, 3'd7, 4};
    tbl[4] = '{128'h00000004_00000003_00000002_00000001, 3'd4, 4};
    tbl[5] = '{128'h11112222_33334444_55556666_77778888, 3'd1, 1};
    tbl[6] = '{128'hCAFEBABE_DEADBEEF_8BADF00D_FEEDFACE, 3'd5, 4};

    m_axis_if.TREADY = 1'b0;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_tvalid", m_axis_if.TVALID, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    ARESETn = 1'b1;
    chk("in_ready_at_release", in_ready, 0);
    @(posedge ACLK);
    #1;
    chk("in_ready_after_release", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      beats_seen = 0;
      send_pkt(tbl[i].data, tbl[i].beats, 1'b0);
      chk($sformatf("tbl%0d_first_beat", i), m_axis_if.TDATA, tbl[i].data[W-1:0]);
      drain();
      chk($sformatf("tbl%0d_beat_count", i), beats_seen, tbl[i].exp_n);
    end

    beats_seen = 0;
    send_pkt(128'h99999999_77777777_66666666_55555555, 3'd3, 1'b0);
    #1;
    tr_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    drain();
    chk("backpressure_count", beats_seen, 3);

    beats_seen = 0;
    send_pkt(128'h0_0_BB000002_BB000001, 3'd2, 1'b1);
    send_pkt(128'hCC000004_CC000003_CC000002_CC000001, 3'd4, 1'b0);
    drain();
    chk("b2b_count", beats_seen, 6);

    beats_seen = 0;
    send_pkt(128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 3'd0, 1'b0);
    t = 0;
    while (beats_seen < 2 && t < 50) begin
      @(posedge ACLK);
      #1;
      t++;
    end
    chk("midrst_beats_before", beats_seen, 2);
    ARESETn = 1'b0;
    #1;
    chk("midrst_tvalid", m_axis_if.TVALID, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    beats_seen = 0;
    send_pkt(128'hE4E4E4E4_E3E3E3E3_E2E2E2E2_E1E1E1E1, 3'd4, 1'b0);
    chk("midrst_fresh_beat0", m_axis_if.TDATA, 32'hE1E1E1E1);
    drain();
    chk("midrst_fresh_count", beats_seen, 4);

    tr_rand = 1'b1;
    repeat (40) begin
      send_pkt({$urandom, $urandom, $urandom, $urandom}, CW'($urandom_range(0, 7)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge ACLK);
      #1;
    end
    drain();
    tr_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected end before 300000");
    $fatal(1);
  end

endmodule
